// File: rtl/a2d_serf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_serf_pkg
//  Description : Shared types and constants for the A/D converter SPI
//                responder model (state encoding, command field positions,
//                channel geometry, optional noise helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package a2d_serf_pkg;

    // Responder state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serf_state_t;

    // Command word layout: [15:14] must be zero, [13:11] channel, rest ignored
    localparam int CMD_CH_MSB  = 13;
    localparam int CMD_CH_LSB  = 11;
    localparam int CMD_PAD_MSB = 15;

    // Channel geometry
    localparam int NUM_CH   = 8;
    localparam int CH_W     = 12;
    localparam int CH_SEL_W = 3;

    // Adds a small signed offset (nz - 8) to a raw sample and clamps the
    // result to the converter range. Two spare bits keep the intermediate
    // sum from wrapping at either end.
    function automatic logic [CH_W-1:0] noisy_sample(
        input logic [CH_W-1:0] raw,
        input logic [3:0]      nz
    );
        logic signed [CH_W+1:0] s;
        s = $signed({2'b00, raw}) + $signed({{(CH_W-2){1'b0}}, nz}) - 14'sd8;
        if (s < 14'sd0)
            noisy_sample = '0;
        else if (s > 14'sd4095)
            noisy_sample = '1;
        else
            noisy_sample = s[CH_W-1:0];
    endfunction

endpackage : a2d_serf_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-flop synchronizer for one asynchronous SPI pin,
//                followed by one history flop that yields single-clk rise
//                and fall pulses. SYNC_STAGES must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain plus one edge-history flop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_lvl  = r_sync[SYNC_STAGES-1];
    assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/a2d_spi_serf.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_spi_serf
//  Description : SPI mode-0 responder modelling an 8-channel 12-bit A/D
//                converter. Each transaction returns the sample of the
//                channel chosen by the previous command and captures the
//                next command. Optional feature macro: A2D_SERF_NOISE_EN
//                (adds LFSR-driven +/- noise with saturation to results).
//  Revision    : 1.0 - initial release
// ============================================================================
module a2d_spi_serf
    import a2d_serf_pkg::*;
#(
    parameter int XFER_BITS   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_SS_n,
    input  logic                     i_SCLK,
    input  logic                     i_MOSI,
    output logic                     o_MISO,
    input  logic [NUM_CH*CH_W-1:0]   i_ana_in,
    output logic [CH_SEL_W-1:0]      o_chnnl,
    output logic                     o_cmd_vld,
    output logic                     o_xfer_err,
    output logic                     o_busy
);

    localparam int                 CNT_W      = $clog2(XFER_BITS + 2);
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(XFER_BITS - 1);
    localparam logic [CNT_W-1:0]   c_CNT_FULL = CNT_W'(XFER_BITS);
    localparam logic [CNT_W-1:0]   c_CNT_OVR  = CNT_W'(XFER_BITS + 1);
    localparam int                 ARM_W      = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]   c_ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    // ------------------------------------------------------------------
    // Pin synchronization and edge detection
    // ------------------------------------------------------------------
    logic w_ss_lvl, w_ss_rise, w_ss_fall;
    logic w_sclk_lvl_unused, w_sclk_rise, w_sclk_fall;
    logic w_mosi_lvl, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk    (clk),
        .rst    (rst),
        .i_d    (i_SS_n),
        .o_lvl  (w_ss_lvl),
        .o_rise (w_ss_rise),
        .o_fall (w_ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .i_d    (i_SCLK),
        .o_lvl  (w_sclk_lvl_unused),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .i_d    (i_MOSI),
        .o_lvl  (w_mosi_lvl),
        .o_rise (w_mosi_rise_unused),
        .o_fall (w_mosi_fall_unused)
    );

    // ------------------------------------------------------------------
    // Channel view of the analog bus
    // ------------------------------------------------------------------
    logic [CH_W-1:0] w_ch [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_ch[g] = i_ana_in[g*CH_W +: CH_W];
    end

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    serf_state_t            r_state;
    logic [XFER_BITS-1:0]   r_tx;
    logic [XFER_BITS-1:0]   r_rx;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [CH_SEL_W-1:0]    r_chnnl;
    logic                   r_miso;
    logic                   r_cmd_vld;
    logic                   r_xfer_err;
    logic                   r_busy;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic                   r_armed;

    // A transaction may start only from IDLE, and only once a genuine
    // high level of SS_n has been seen after reset; a select that is
    // already low at reset release is therefore ignored.
    logic w_accept;
    assign w_accept = (r_state == IDLE) && r_armed && w_ss_fall;

    // ------------------------------------------------------------------
    // Result word loaded at the start of a transaction
    // ------------------------------------------------------------------
    logic [CH_W-1:0]      w_ld_val;
    logic [XFER_BITS-1:0] w_ld_word;

`ifdef A2D_SERF_NOISE_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_ld_val  = noisy_sample(w_ch[r_chnnl], r_lfsr[3:0]);

    // Noise LFSR steps once per accepted transaction start
    always_ff @(posedge clk) begin
        if (rst)
            r_lfsr <= 16'hACE1;
        else if (w_accept)
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
`else
    assign w_ld_val = w_ch[r_chnnl];
`endif

    assign w_ld_word = {{(XFER_BITS-CH_W){1'b0}}, w_ld_val};

    // Arms transaction acceptance once synchronized SS_n reflects the pin
    // and has been observed high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            if (r_arm_cnt != c_ARM_DONE)
                r_arm_cnt <= r_arm_cnt + 1'b1;
            if ((r_arm_cnt == c_ARM_DONE) && w_ss_lvl)
                r_armed <= 1'b1;
        end
    end

    // Transaction FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_bit_cnt  <= '0;
            r_chnnl    <= '0;
            r_miso     <= 1'b0;
            r_cmd_vld  <= 1'b0;
            r_xfer_err <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_cmd_vld  <= 1'b0;
            r_xfer_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    r_miso <= 1'b0;
                    if (w_accept) begin
                        r_tx      <= w_ld_word;
                        r_miso    <= w_ld_word[XFER_BITS-1];
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // SS_n rising takes priority over any coincident SCLK edge
                    if (w_ss_rise) begin
                        r_busy <= 1'b0;
                        r_miso <= 1'b0;
                        if (r_bit_cnt == c_CNT_FULL) begin
                            r_state <= DONE;
                        end else begin
                            r_xfer_err <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end else if (w_sclk_rise) begin
                        r_rx <= {r_rx[XFER_BITS-2:0], w_mosi_lvl};
                        if (r_bit_cnt != c_CNT_OVR)
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else if (w_sclk_fall && (r_bit_cnt >= c_CNT_ONE) &&
                                 (r_bit_cnt <= c_CNT_LAST)) begin
                        // MISO follows the bit that moves into the MSB
                        r_tx   <= {r_tx[XFER_BITS-2:0], 1'b0};
                        r_miso <= r_tx[XFER_BITS-2];
                    end
                end
                DONE: begin
                    if (r_rx[CMD_PAD_MSB -: 2] == 2'b00) begin
                        r_chnnl   <= r_rx[CMD_CH_MSB:CMD_CH_LSB];
                        r_cmd_vld <= 1'b1;
                    end else begin
                        r_xfer_err <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Bits deliberately left unread: low command field and the shifted-out
    // MSB of the result register (MISO is taken from its own flop)
    logic w_unused;
    assign w_unused = ^{r_rx[CMD_CH_LSB-1:0], r_tx[XFER_BITS-1],
                        w_sclk_lvl_unused, w_mosi_rise_unused, w_mosi_fall_unused};

    assign o_MISO     = r_miso;
    assign o_chnnl    = r_chnnl;
    assign o_cmd_vld  = r_cmd_vld;
    assign o_xfer_err = r_xfer_err;
    assign o_busy     = r_busy;

endmodule : a2d_spi_serf
`default_nettype wire

// File: tb/tb_a2d_spi_serf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_a2d_spi_serf
//  Description : Self-checking bench for a2d_spi_serf: directed vector
//                table, reset/abort sequences and randomized transactions
//                checked against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_a2d_spi_serf;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss_n, sclk, mosi;
    logic [95:0] ana;
    wire         miso;
    wire  [2:0]  chnnl;
    wire         cmd_vld, xfer_err, busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_vld  = 0;
    int n_err  = 0;
    int model_ch;

    always #10 clk = ~clk;

    a2d_spi_serf #(.XFER_BITS(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_SS_n     (ss_n),
        .i_SCLK     (sclk),
        .i_MOSI     (mosi),
        .o_MISO     (miso),
        .i_ana_in   (ana),
        .o_chnnl    (chnnl),
        .o_cmd_vld  (cmd_vld),
        .o_xfer_err (xfer_err),
        .o_busy     (busy)
    );

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (cmd_vld)  n_vld++;
        if (xfer_err) n_err++;
    end

    typedef struct {
        logic [15:0] cmd;
        int          nbits;
        logic [15:0] word;
        int          vld;
        int          err;
        logic [2:0]  ch;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Compares the captured MISO bits with the expected raw sample
    task automatic chk_word(input string nm, input logic [15:0] got,
                            input logic [11:0] raw, input int nbits);
        logic [15:0] m;
`ifdef A2D_SERF_NOISE_EN
        int lo, hi;
        if (nbits >= 16) begin
            lo = (int'(raw) < 8) ? 0 : int'(raw) - 8;
            hi = (int'(raw) + 7 > 4095) ? 4095 : int'(raw) + 7;
            n_chk++;
            if (int'(got) >= lo && int'(got) <= hi) n_pass++;
            else $display("FAIL %s: got %0h expected range %0h..%0h", nm, got, lo, hi);
        end
`else
        m = (nbits >= 16) ? 16'hFFFF : ~(16'hFFFF >> nbits);
        chk(nm, {16'h0, got & m}, {16'h0, {4'h0, raw} & m});
`endif
    endtask

    // One SPI transaction as the monarch would drive it (16-clk half periods)
    task automatic xfer(input logic [15:0] cmd, input int nbits, input bit scramble,
                        output logic [15:0] word, output logic busy_mid,
                        output int dv, output int de);
        int v0, e0;
        v0 = n_vld; e0 = n_err;
        word = '0; busy_mid = 1'b0;
        @(negedge clk) ss_n = 1'b0;
        repeat (8) @(negedge clk);
        if (scramble) ana = {$urandom, $urandom, $urandom};
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? cmd[15-i] : 1'b0;
            repeat (16) @(negedge clk);
            if (i < 16) word[15-i] = miso;
            if (i == 2) busy_mid = busy;
            sclk = 1'b1;
            repeat (16) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        ss_n = 1'b1; mosi = 1'b0;
        repeat (12) @(negedge clk);
        dv = n_vld - v0;
        de = n_err - e0;
    endtask

    // Runs a transaction and checks it against the transaction-level model
    task automatic run_model(input string nm, input logic [15:0] cmd,
                             input int nbits, input bit scramble);
        logic [95:0] snap;
        logic [11:0] raw;
        logic [15:0] word;
        logic        bm;
        int          dv, de, ev, ee;
        snap = ana;
        raw  = snap[model_ch*12 +: 12];
        xfer(cmd, nbits, scramble, word, bm, dv, de);
        ev = 0; ee = 0;
        if (nbits == 16 && cmd[15:14] == 2'b00) begin
            ev = 1; model_ch = int'(cmd[13:11]);
        end else begin
            ee = 1;
        end
        chk_word({nm, " miso"}, word, raw, nbits);
        chk({nm, " cmd_vld"}, dv, ev);
        chk({nm, " xfer_err"}, de, ee);
        chk({nm, " chnnl"}, {29'h0, chnnl}, model_ch);
        chk({nm, " busy_mid"}, {31'h0, bm}, 1);
        chk({nm, " busy_end"}, {31'h0, busy}, 0);
    endtask

    initial begin
        logic [15:0] word;
        logic        bm;
        int          dv, de, v0, e0, r, nb;
        logic [15:0] cmd;

        tbl[0] = '{16'h2000, 16, 16'h0123, 1, 0, 3'd4};
        tbl[1] = '{16'h2800, 16, 16'h0A5C, 1, 0, 3'd5};
        tbl[2] = '{16'hC000, 16, 16'h05B7, 0, 1, 3'd5};
        tbl[3] = '{16'h0000,  9, 16'h05B7, 0, 1, 3'd5};
        tbl[4] = '{16'h0800, 16, 16'h05B7, 1, 0, 3'd1};
        tbl[5] = '{16'h1000, 17, 16'h01E1, 0, 1, 3'd1};
        tbl[6] = '{16'h3800, 16, 16'h01E1, 1, 0, 3'd7};
        tbl[7] = '{16'h4000, 16, 16'h07E7, 0, 1, 3'd7};

        rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        ana = {12'h7E7, 12'h6D6, 12'h5B7, 12'hA5C, 12'h3B3, 12'h2C2, 12'h1E1, 12'h123};
        repeat (4) @(negedge clk);
        chk("rst miso",  {31'h0, miso}, 0);
        chk("rst chnnl", {29'h0, chnnl}, 0);
        chk("rst vld",   {31'h0, cmd_vld}, 0);
        chk("rst err",   {31'h0, xfer_err}, 0);
        chk("rst busy",  {31'h0, busy}, 0);
        rst = 1'b0;
        model_ch = 0;
        repeat (8) @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            xfer(tbl[i].cmd, tbl[i].nbits, 1'b0, word, bm, dv, de);
            chk_word($sformatf("tbl%0d miso", i), word, tbl[i].word[11:0], tbl[i].nbits);
            chk($sformatf("tbl%0d vld", i), dv, tbl[i].vld);
            chk($sformatf("tbl%0d err", i), de, tbl[i].err);
            chk($sformatf("tbl%0d chnnl", i), {29'h0, chnnl}, {29'h0, tbl[i].ch});
            chk($sformatf("tbl%0d busy_mid", i), {31'h0, bm}, 1);
            chk($sformatf("tbl%0d busy_end", i), {31'h0, busy}, 0);
        end
        model_ch = 7;

        // Reset asserted in the middle of a transaction, select left low
        @(negedge clk) ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            repeat (16) @(negedge clk); sclk = 1'b1;
            repeat (16) @(negedge clk); sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("mid busy before rst", {31'h0, busy}, 1);
        v0 = n_vld; e0 = n_err;
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst miso",  {31'h0, miso}, 0);
        chk("mid rst chnnl", {29'h0, chnnl}, 0);
        chk("mid rst busy",  {31'h0, busy}, 0);
        chk("mid rst vld",   {31'h0, cmd_vld}, 0);
        chk("mid rst err",   {31'h0, xfer_err}, 0);
        rst = 1'b0; mosi = 1'b0;
        model_ch = 0;
        repeat (20) @(negedge clk);
        chk("low ss after rst busy", {31'h0, busy}, 0);
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("low ss after rst pulses", (n_vld - v0) + (n_err - e0), 0);
        run_model("post rst", 16'h1800, 16, 1'b0);

        // Randomized transactions against the model
        for (int i = 0; i < 24; i++) begin
            cmd = 16'($urandom);
            if ($urandom_range(0, 3) != 0) cmd[15:14] = 2'b00;
            r = int'($urandom_range(0, 7));
            nb = (r == 0) ? int'($urandom_range(3, 15)) : (r == 1) ? 17 : 16;
            run_model($sformatf("rnd%0d", i), cmd, nb, 1'b1);
        end

`ifdef A2D_SERF_NOISE_EN
        // Saturation near both ends of the range
        ana = {72'h0, 12'h003, 12'hFFE};
        for (int i = 0; i < 8; i++)
            run_model($sformatf("nz%0d", i), (i % 2 == 0) ? 16'h0800 : 16'h0000, 16, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_a2d_spi_serf
`default_nettype wire
